seq_divider32: RTL
==================

# seq_divider32

Multi-cycle 32-bit integer divider serving the RV32M DIV/DIVU/REM/REMU path. It sits directly under the divide reservation station.

- The station issues one operand pair per request with `in_en`.
- The divider runs a radix-2 restoring loop.
- It returns quotient and remainder together, marked by a one-cycle `out_en` pulse.
- The station selects quotient or remainder itself.

## Interface
Parameters: none.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_en` input 1: request strobe; `a`, `b` and `div_signed` are valid in this cycle.
- `a` input 32: dividend.
- `b` input 32: divisor.
- `div_signed` input 1: 1 selects signed (DIV/REM), 0 selects unsigned (DIVU/REMU).
- `out_en` output 1: one-cycle pulse; `q`/`rem` valid this cycle.
- `idle` output 1: the divider can accept a request; combinational.
- `q` output 32: quotient, registered.
- `rem` output 32: remainder, registered.

## Operation
- States:
  - IDLE.
  - CALC: 32 iterations, 5-bit counter.
  - FIX: sign and special-case correction.
- Definition of `idle`: `idle = (state==IDLE) && !in_en`.
  - `idle` drops in the same cycle a request is presented.
  - A requester that registers its strobe therefore never issues twice back-to-back.
- Accept: a request is accepted at a rising edge with `in_en`=1 and state IDLE.
  - `in_en` in any other state is ignored; no queueing, no error.
- On accept, the block latches:
  - `neg_q` = `div_signed & (a[31]^b[31])`.
  - `neg_r` = `div_signed & a[31]`.
  - `dz` = (`b`==0).
  - `ovf` = `div_signed & a==32'h8000_0000 & b==32'hFFFF_FFFF`.
  - Magnitudes |a| and |b|: two's-complement negate when signed and negative; 32'h8000_0000 stays unsigned 2^31.
- State transition on accept: go to CALC with counter = 0.
- CALC, one iteration per cycle on a 33-bit partial remainder:
  - Shift the next dividend bit in, MSB first.
  - Trial-subtract |b|.
  - If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After iteration 31, go to FIX.
- FIX produces the final results and sets `out_en` <= 1; state returns to IDLE.
  - `dz`: `q` = 32'hFFFF_FFFF, `rem` = `a`, regardless of signedness.
  - `ovf`: `q` = 32'h8000_0000, `rem` = 0.
  - Otherwise: `q` = the quotient negated if `neg_q`, and `rem` = the remainder negated if `neg_r`.
  - The remainder's sign follows the dividend; division truncates toward zero.
- `q`/`rem` hold their value from the `out_en` cycle until the next FIX write.
- `out_en` is high for exactly one cycle per accepted request.

## Timing
- Reset values: `out_en`=0, `q`=0, `rem`=0, state IDLE, counter 0.
  - `idle` = `!in_en` during and after reset.
- Reset asserted mid-operation aborts immediately: no `out_en` pulse, and the result is lost.
- Latency: a request accepted at the edge ending cycle N produces `out_en` in cycle N+34.
  - N+1..N+32 are CALC.
  - N+33 is FIX.
- Throughput:
  - During the `out_en` cycle, state is IDLE, so `idle`=1 when `in_en`=0.
  - A new request presented in the `out_en` cycle is accepted, giving back-to-back operations every 34 cycles.
- `in_en` arriving while busy is dropped and does not disturb the current operation.

## Configuration
- `DIV_EARLY_OUT_EN` defined: the early-out path is compiled in.
  - An accept with `dz` or `ovf` set goes straight from IDLE to FIX, skipping CALC.
  - `out_en` appears in cycle N+2.
  - The results are identical to the undefined case.
- `DIV_EARLY_OUT_EN` undefined: every request takes the full 34-cycle latency, special cases included.

## Test plan
- Unsigned basic: `a`=100, `b`=7, `div_signed`=0.
  - `out_en` in cycle N+34 with `q`=14, `rem`=2.
  - `idle`=0 during N..N+33.
- Signed mixed signs: `a`=-7 (32'hFFFF_FFF9), `b`=2, `div_signed`=1.
  - `q`=32'hFFFF_FFFD (-3), `rem`=32'hFFFF_FFFF (-1).
- Unsigned large operands: `a`=32'hFFFF_FFFF, `b`=32'hFFFF_FFFE, `div_signed`=0.
  - `q`=1, `rem`=1.
- Divide by zero, signed: `a`=-5, `b`=0.
  - `q`=32'hFFFF_FFFF, `rem`=32'hFFFF_FFFB.
  - `out_en` at N+2 with `DIV_EARLY_OUT_EN` defined, N+34 without.
- Overflow: `a`=32'h8000_0000, `b`=32'hFFFF_FFFF, `div_signed`=1.
  - `q`=32'h8000_0000, `rem`=0.
  - With `div_signed`=0 instead: `q`=0, `rem`=32'h8000_0000.
- Handshake and reset:
  - Pulse `in_en` at cycles N, N+5 (ignored) and N+34 (accepted).
  - Expect exactly two `out_en` pulses, at N+34 and N+68.
  - Assert `rst` at N+40: no second pulse, and `q`=`rem`=0.

Source files
------------

// File: rtl/seq_divider32_if.sv
// Request/response bundle between the divide reservation station and seq_divider32.
// The station owns the master side; the divider is the slave.
interface seq_divider32_if;
  logic        in_en;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_signed;
  logic        out_en;
  logic        idle;
  logic [31:0] q;
  logic [31:0] rem;

  modport master (output in_en, a, b, div_signed, input out_en, idle, q, rem);
  modport slave  (input in_en, a, b, div_signed, output out_en, idle, q, rem);
endinterface

// File: rtl/seq_divider32.sv
// Radix-2 restoring 32-bit divider for RV32M DIV/DIVU/REM/REMU: one request, one out_en pulse.
// Define DIV_EARLY_OUT_EN to send divide-by-zero and overflow straight to FIX, skipping CALC.
module seq_divider32 (
  input  logic            clk,
  input  logic            rst,
  seq_divider32_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;    // dividend bits shift out MSB first, quotient bits shift in at LSB
  logic [31:0] pr_q;
  logic [31:0] bmag_q;
  logic [31:0] a_q;
  logic        neg_q_q, neg_r_q, dz_q, ovf_q;
  logic [31:0] q_q, rem_q;
  logic        out_en_q;

  logic        accept;
  logic [31:0] amag, bmag;
  logic        dz_d, ovf_d;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] pr_d, dvd_d;

  assign accept = (state_q == IDLE) && bus.in_en;
  assign amag   = (bus.div_signed && bus.a[31]) ? -bus.a : bus.a;
  assign bmag   = (bus.div_signed && bus.b[31]) ? -bus.b : bus.b;
  assign dz_d   = (bus.b == 32'd0);
  assign ovf_d  = bus.div_signed && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);

  // Partial remainder stays below |b|, so 32 bits of storage suffice; the trial needs 33.
  assign trial = {pr_q, dvd_q[31]} - {1'b0, bmag_q};
  assign ge    = !trial[32];
  assign pr_d  = ge ? trial[31:0] : {pr_q[30:0], dvd_q[31]};
  assign dvd_d = {dvd_q[30:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      dvd_q    <= 32'd0;
      pr_q     <= 32'd0;
      bmag_q   <= 32'd0;
      a_q      <= 32'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      q_q      <= 32'd0;
      rem_q    <= 32'd0;
      out_en_q <= 1'b0;
    end else begin
      out_en_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          dvd_q   <= amag;
          pr_q    <= 32'd0;
          bmag_q  <= bmag;
          a_q     <= bus.a;
          neg_q_q <= bus.div_signed & (bus.a[31] ^ bus.b[31]);
          neg_r_q <= bus.div_signed & bus.a[31];
          dz_q    <= dz_d;
          ovf_q   <= ovf_d;
          cnt_q   <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
          state_q <= (dz_d || ovf_d) ? FIX : CALC;
`else
          state_q <= CALC;
`endif
        end
        CALC: begin
          pr_q  <= pr_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            q_q   <= 32'hFFFF_FFFF;
            rem_q <= a_q;
          end else if (ovf_q) begin
            q_q   <= 32'h8000_0000;
            rem_q <= 32'd0;
          end else begin
            q_q   <= neg_q_q ? -dvd_q : dvd_q;
            rem_q <= neg_r_q ? -pr_q  : pr_q;
          end
          out_en_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.idle   = (state_q == IDLE) && !bus.in_en;
  assign bus.out_en = out_en_q;
  assign bus.q      = q_q;
  assign bus.rem    = rem_q;
endmodule
